// File: rtl/studio2_pkg.sv
// studio2_pkg: shared constants and scan-code lookup for the Studio II keypad front end
package studio2_pkg;
  localparam int NUM_KEYS = 10;
  localparam logic [2:0] KEYSEL_PORT = 3'd2;
  localparam int EF1_IDX = 0;
  localparam int EF2_IDX = 1;
  localparam int EF3_IDX = 2;
  localparam int EF4_IDX = 3;
  localparam logic [7:0] KP1_CODES [NUM_KEYS] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] KP2_CODES [NUM_KEYS] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  function automatic logic [4:0] key_lookup(input logic [7:0] code, input logic pad2);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (code == (pad2 ? KP2_CODES[i] : KP1_CODES[i])) r = {1'b1, 4'(i)};
    return r;
  endfunction
endpackage

// File: rtl/studio2_keypad_hold.sv
// studio2_keypad_hold: one keypad's pressed mask with a minimum-hold timer and deferred releases
module studio2_keypad_hold
  import studio2_pkg::*;
#(
  parameter int HOLD_W = 20,
  parameter int HOLD_CYCLES = 500000
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                make,
  input  logic                brk,
  input  logic [3:0]          key,
  output logic [NUM_KEYS-1:0] state
);
  logic [NUM_KEYS-1:0] pend, pend_n, state_n, mk, bk;
  logic [HOLD_W-1:0]   timer, timer_n;
  logic                hold_on, expire;
  // next state: breaks during the hold are deferred until the timer runs out
  always_comb begin
    mk      = make ? NUM_KEYS'(1) << key : '0;
    bk      = brk ? NUM_KEYS'(1) << key : '0;
    hold_on = timer != '0;
    expire  = timer == HOLD_W'(1);
    pend_n  = hold_on ? (pend | (bk & state)) & ~mk : '0;
    state_n = (state | mk) & ~(hold_on ? '0 : bk) & ~(expire ? pend_n : '0);
    timer_n = make ? HOLD_W'(HOLD_CYCLES) : hold_on ? timer - HOLD_W'(1) : '0;
  end
  // state, pending and timer registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= '0;
      pend  <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      pend  <= expire ? '0 : pend_n;
      timer <= timer_n;
    end
  end
endmodule

// File: rtl/studio2_keypad.sv
// studio2_keypad: PS/2 to dual keypad decode, OUT 2 key-select latch and CDP1802 EF outputs
module studio2_keypad
  import studio2_pkg::*;
#(
  parameter int HOLD_W = 20,
  parameter int HOLD_CYCLES = 500000
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [10:0]         ps2_key,
  input  logic                io_out,
  input  logic [2:0]          io_n,
  input  logic [7:0]          io_dout,
  input  logic                efx,
  output logic [3:0]          ef_n,
  output logic [3:0]          key_sel,
  output logic [NUM_KEYS-1:0] kp1_state,
  output logic [NUM_KEYS-1:0] kp2_state
);
  logic        tog_q, primed, valid;
  logic [4:0]  hit1, hit2;
  logic [15:0] kp1_ext, kp2_ext;
  // decode: an event is a toggle change once primed; extended codes are dropped
  always_comb begin
    valid   = primed && (ps2_key[10] != tog_q) && !ps2_key[8];
    hit1    = key_lookup(ps2_key[7:0], 1'b0);
    hit2    = key_lookup(ps2_key[7:0], 1'b1);
    kp1_ext = {6'b0, kp1_state};
    kp2_ext = {6'b0, kp2_state};
  end
  studio2_keypad_hold #(.HOLD_W(HOLD_W), .HOLD_CYCLES(HOLD_CYCLES)) u_kp1 (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .make(valid && hit1[4] && ps2_key[9]), .brk(valid && hit1[4] && !ps2_key[9]),
    .key(hit1[3:0]), .state(kp1_state)
  );
  studio2_keypad_hold #(.HOLD_W(HOLD_W), .HOLD_CYCLES(HOLD_CYCLES)) u_kp2 (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .make(valid && hit2[4] && ps2_key[9]), .brk(valid && hit2[4] && !ps2_key[9]),
    .key(hit2[3:0]), .state(kp2_state)
  );
  // toggle capture; the first cycle after reset only primes the detector
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q  <= 1'b0;
      primed <= 1'b0;
    end else begin
      tog_q  <= ps2_key[10];
      primed <= 1'b1;
    end
  end
  // key-select latch from OUT 2; selects 10-15 read as zero in the extended masks
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) key_sel <= 4'hF;
    else if (io_out && io_n == KEYSEL_PORT) key_sel <= io_dout[3:0];
  end
  // registered EF lines, all active low
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) ef_n <= 4'b1111;
    else begin
      ef_n[EF1_IDX] <= efx;
      ef_n[EF2_IDX] <= 1'b1;
      ef_n[EF3_IDX] <= ~kp1_ext[key_sel];
      ef_n[EF4_IDX] <= ~kp2_ext[key_sel];
    end
  end
endmodule

// File: tb/tb_studio2_keypad.sv
// tb_studio2_keypad: directed self-checking bench for the keypad front end
module tb_studio2_keypad;
  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] ps2_key;
  logic        io_out;
  logic [2:0]  io_n;
  logic [7:0]  io_dout;
  logic        efx;
  logic [3:0]  ef_n, key_sel;
  logic [9:0]  kp1_state, kp2_state;
  int          checks = 0;
  int          errors = 0;

  studio2_keypad #(.HOLD_W(20), .HOLD_CYCLES(100)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .io_out(io_out),
    .io_n(io_n), .io_dout(io_dout), .efx(efx), .ef_n(ef_n), .key_sel(key_sel),
    .kp1_state(kp1_state), .kp2_state(kp2_state)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic key(input logic ext, input logic pressed, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    tick(1);
  endtask

  task automatic out(input logic [2:0] port, input logic [7:0] data);
    io_out = 1'b1; io_n = port; io_dout = data;
    tick(1);
    io_out = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ps2_key = 11'h400; io_out = 1'b0; io_n = 3'd0; io_dout = 8'h00; efx = 1'b1;
    #23;
    chk("rst_ef", 16'(ef_n), 16'hF);
    chk("rst_sel", 16'(key_sel), 16'hF);
    reset_n = 1'b1;
    tick(3);
    chk("prime_kp1", 16'(kp1_state), 16'h0);
    chk("prime_kp2", 16'(kp2_state), 16'h0);
    chk("prime_ef", 16'(ef_n), 16'hF);
    out(3'd2, 8'h05);
    chk("sel5", 16'(key_sel), 16'h5);
    key(1'b0, 1'b1, 8'h2E);
    chk("mk2E_kp1", 16'(kp1_state), 16'h020);
    chk("mk2E_ef_lat", 16'(ef_n), 16'hF);
    tick(1);
    chk("mk2E_ef", 16'(ef_n), 16'b1011);
    tick(8);
    key(1'b0, 1'b0, 8'h2E);
    chk("brk2E_held", 16'(kp1_state), 16'h020);
    tick(89);
    chk("hold99_kp1", 16'(kp1_state), 16'h020);
    chk("hold99_ef", 16'(ef_n), 16'b1011);
    tick(1);
    chk("hold100_kp1", 16'(kp1_state), 16'h0);
    chk("hold100_ef", 16'(ef_n), 16'b1011);
    tick(1);
    chk("hold101_ef", 16'(ef_n), 16'hF);
    out(3'd2, 8'h03);
    key(1'b0, 1'b1, 8'h7A);
    key(1'b0, 1'b1, 8'h26);
    chk("both_kp1", 16'(kp1_state), 16'h008);
    chk("both_kp2", 16'(kp2_state), 16'h008);
    tick(1);
    chk("both_ef", 16'(ef_n), 16'b0011);
    out(3'd2, 8'h0C);
    tick(1);
    chk("selC_ef", 16'(ef_n), 16'hF);
    key(1'b0, 1'b0, 8'h7A);
    key(1'b0, 1'b0, 8'h26);
    tick(100);
    chk("rel_kp1", 16'(kp1_state), 16'h0);
    chk("rel_kp2", 16'(kp2_state), 16'h0);
    efx = 1'b0;
    tick(1);
    chk("efx_lo", 16'(ef_n), 16'b1110);
    efx = 1'b1;
    tick(1);
    chk("efx_hi", 16'(ef_n), 16'hF);
    out(3'd3, 8'h05);
    chk("port3_sel", 16'(key_sel), 16'hC);
    key(1'b1, 1'b1, 8'h69);
    chk("ext69_kp2", 16'(kp2_state), 16'h0);
    key(1'b0, 1'b1, 8'h1C);
    chk("other_kp1", 16'(kp1_state), 16'h0);
    chk("other_kp2", 16'(kp2_state), 16'h0);
    key(1'b0, 1'b1, 8'h16);
    tick(101);
    key(1'b0, 1'b0, 8'h16);
    chk("brk_nohold", 16'(kp1_state), 16'h0);
    key(1'b0, 1'b1, 8'h16);
    tick(4);
    key(1'b0, 1'b0, 8'h16);
    tick(94);
    chk("exp99_kp1", 16'(kp1_state), 16'h002);
    key(1'b0, 1'b1, 8'h1E);
    chk("mk_at_exp", 16'(kp1_state), 16'h004);
    key(1'b0, 1'b0, 8'h1E);
    chk("reload_held", 16'(kp1_state), 16'h004);
    tick(100);
    chk("reload_exp", 16'(kp1_state), 16'h0);
    out(3'd2, 8'h05);
    key(1'b0, 1'b1, 8'h2E);
    tick(3);
    chk("pre_rst_ef", 16'(ef_n), 16'b1011);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_kp1", 16'(kp1_state), 16'h0);
    chk("mid_rst_ef", 16'(ef_n), 16'hF);
    chk("mid_rst_sel", 16'(key_sel), 16'hF);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h2E};
    tick(1);
    reset_n = 1'b1;
    tick(3);
    chk("stale_kp1", 16'(kp1_state), 16'h0);
    key(1'b0, 1'b1, 8'h2E);
    chk("post_rst_kp1", 16'(kp1_state), 16'h020);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/studio2_keypad.md
Name: studio2_keypad

Overview:
Keypad front end for the Studio II core. Turns PS/2 key events into the state of two 10-key keypads and latches the key-select digit the CPU writes with OUT 2. It drives the CDP1802 EF inputs: EF3 for keypad 1, EF4 for keypad 2, and EF1 from the 1861 video EFx output. It replaces the ad-hoc key decode and EF mux in the top level, which sits directly upstream of the cdp1802 EF port.

Parameters:
HOLD_W, 20, width of the per-keypad minimum-hold timer.
HOLD_CYCLES, 500000, minimum number of clk_sys cycles a key stays reported pressed after its make event (about 1 frame); 0 disables hold.

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scan code
io_out  in  1  CPU OUT strobe, one clk_sys pulse
io_n  in  3  CPU N lines
io_dout  in  8  CPU OUT data
efx  in  1  pixie EFx, active low
ef_n  out  4  EF4..EF1 to CPU, active low, [0]=EF1
key_sel  out  4  latched select digit
kp1_state  out  10  keypad 1 reported-pressed mask, bit n = key n
kp2_state  out  10  keypad 2 reported-pressed mask

Behaviour:
- Reset values: ef_n=4'b1111, key_sel=4'hF, kp1_state=0, kp2_state=0, both hold timers 0, pending masks 0, primed=0.
- Event detect: the toggle is registered each cycle. The first cycle after reset only captures the toggle and sets primed; no event is generated. After that, event = primed && (toggle != registered toggle).
- Decode applies only when ps2_key[8]=0; extended codes are ignored.
- Keypad 1 digits 1-9,0: 16,1E,26,25,2E,36,3D,3E,46,45.
- Keypad 2 numpad digits 0-9: 70,69,72,7A,6B,73,74,6C,75,7D.
- Other codes are ignored.
- Make (pressed=1): set the key bit, clear its pending bit, load that keypad's timer with HOLD_CYCLES.
- Break (pressed=0):
  - timer==0: clear the key bit immediately.
  - timer!=0: set the key's pending bit.
  - Break of a key that is not set: no effect.
- Timer: decrements each cycle while nonzero. On the cycle it reaches 0, every pending bit clears the matching state bit and the pending mask clears.
- Simultaneous make and expiry on the same keypad: the made key stays set and its pending bit clears, other pending keys release, the timer reloads.
- Select latch: io_out=1 && io_n==3'd2 → key_sel <= io_dout[3:0]. Other ports are ignored. A select write and a key event in the same cycle both apply.
- EF outputs (registered, 1-cycle latency from state/key_sel/efx):
  - ef_n[0]=efx.
  - ef_n[1]=1.
  - ef_n[2]=~(key_sel<10 && kp1_state[key_sel]).
  - ef_n[3]=~(key_sel<10 && kp2_state[key_sel]).
  - key_sel 10-15 → EF3/EF4 inactive.
- Multiple keys held: all tracked independently (full rollover).
- Reset mid-hold: everything returns to reset values asynchronously. A stale toggle after release is absorbed by the primed rule.

Decomposition:
- Package studio2_pkg:
  - scan-code constant arrays KP1_CODES[10], KP2_CODES[10]
  - KEYSEL_PORT=3'd2
  - EF bit indices EF1_IDX..EF4_IDX
  - NUM_KEYS=10
- One sub-module studio2_keypad_hold, instanced twice, one per keypad:
  - inputs: make/break strobes and key index
  - contains: state mask, pending mask and hold timer
  - output: state mask
- The top block holds event detect, decode, select latch and EF register.

Test Plan:
- Reset, toggle already 1 at release, no change → kp1_state=0, kp2_state=0, ef_n=4'b1111 (no spurious event).
- OUT 2 data 8'h05; make code 2E → 2 cycles later ef_n[2]=0, ef_n[3]=1, kp1_state=10'h020.
- HOLD_CYCLES=100; make 2E, break 2E after 10 cycles → kp1_state[5] stays 1 until cycle 100 after the make, then 0; ef_n[2] rises one cycle later.
- key_sel=3; make numpad 7A, then make 26 → ef_n[3]=0 and ef_n[2]=0 together. OUT 2 data 8'h0C → both EF3 and EF4 return to 1.
- efx toggles 1→0→1 with no keys pressed → ef_n[0] follows with 1-cycle delay, ef_n[3:1]=3'b111; OUT on port 3 leaves key_sel unchanged.
- Extended make code 0x69 (E0 69) → no state change. Assert reset_n low mid-hold → all outputs at reset values in the same cycle.
